bitstream_self_loader: RTL and testbench
========================================

// Module: bitstream_self_loader
// PURPOSE
//  Sequences fabric configuration through the eFPGA_top self-write port.
//  Reads a byte-wide bitstream from a synchronous ROM/BRAM and packs 4 bytes big-endian
//  into each 32-bit SelfWriteData word. Issues one SelfWriteStrobe per word with
//  programmable setup/hold spacing.
//  Sits between on-chip bitstream storage and eFPGA_top, replacing manual strobe sequencing.
// PARAMETERS
//  MAX_BITBYTES  16384  bitstream store size in bytes; length requests are clamped to it
//  ADDR_W        14     ROM byte-address width (clog2(MAX_BITBYTES))
//  PRE_GAP       2      cycles SelfWriteData is stable before the strobe (>=1)
//  POST_GAP      2      cycles SelfWriteData is held after the strobe (>=1)
// PORTS
//  CLK              in   1       clock; all logic on rising edge
//  resetn           in   1       asynchronous, active-low reset
//  start            in   1       1-cycle request; sampled only in IDLE
//  len_bytes        in   ADDR_W+1  bitstream length in bytes; sampled with start
//  abort            in   1       cancel the load; highest priority after reset
//  rom_en           out  1       ROM read enable
//  rom_addr         out  ADDR_W  ROM byte address
//  rom_data         in   8       ROM read data, valid 1 cycle after rom_en
//  SelfWriteData    out  32      word to fabric, {b[4k],b[4k+1],b[4k+2],b[4k+3]}
//  SelfWriteStrobe  out  1       1-cycle write strobe to fabric
//  busy             out  1       high from the cycle after an accepted start until DONE
//  done             out  1       1-cycle pulse when the load completes (not on abort)
//  words_written    out  ADDR_W-1  number of strobes issued in the current/last load
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal counters 0.
//  States and transitions:
//   IDLE   -> on start: latch L = min(len_bytes, MAX_BITBYTES) and clear words_written.
//             If L == 0, go to DONE; otherwise go to FETCH.
//   FETCH  -> 5 cycles; rom_en=1 with rom_addr=4k+j on cycles j=0..3.
//             rom_data is captured on cycles 1..4 into byte lanes [31:24]..[7:0].
//             Any byte with address >= L is forced to 8'h00 (tail padding); the ROM read
//             still occurs.
//             At the end of cycle 4, the packed word is registered onto SelfWriteData.
//             Next state: SETUP.
//   SETUP  -> PRE_GAP cycles; SelfWriteData stable, strobe 0. Next state: STROBE.
//   STROBE -> exactly 1 cycle with SelfWriteStrobe=1; words_written increments at this edge.
//             Next state: HOLD.
//   HOLD   -> POST_GAP cycles with data held. Then:
//             if 4(k+1) >= L, go to DONE; else k++ and go to FETCH.
//   DONE   -> done=1 for exactly 1 cycle; busy=0. Next state: IDLE.
//  Timing:
//   Word period = 5+PRE_GAP+1+POST_GAP cycles (10 at defaults).
//   SelfWriteData changes only on the FETCH->SETUP edge. It retains its last value in IDLE.
//   Latency: start at edge E gives the first strobe at edge E+1+5+PRE_GAP (8 at defaults).
//  Boundary and priority cases:
//   - start while busy: ignored, no effect.
//   - start and abort in the same cycle in IDLE: abort wins and start is dropped.
//   - abort in any non-IDLE state: IDLE at the next edge. SelfWriteStrobe and rom_en are 0
//     from that edge. A partially fetched word is never strobed. done is not pulsed.
//     words_written is kept.
//   - resetn low mid-load: immediate return to reset values, regardless of state.
//   - L not a multiple of 4: last word is zero-padded. Strobe count = ceil(L/4).
//   - L = MAX_BITBYTES: the final address is MAX_BITBYTES-1, with no wrap to 0.
//   - rom_addr is never >= MAX_BITBYTES.
// TESTING
//  1. ROM bytes 01..08, len=8:
//     -> 2 strobes with data 0x01020304 then 0x05060708, strobes 10 cycles apart.
//     -> done 3 cycles after the 2nd strobe; words_written=2.
//  2. len=6, same ROM:
//     -> 2nd word is 0x05060000; words_written=2; done pulses once.
//  3. len=0:
//     -> done 2 cycles after start; no strobe; no rom_en; busy stays 0.
//  4. len=16, abort asserted the cycle after the 2nd strobe:
//     -> no further strobe; done stays 0; busy=0 next cycle; words_written=2.
//  5. start pulsed again mid-load, then resetn pulsed low in SETUP:
//     -> 2nd start ignored. On reset, outputs go to 0 immediately.
//     -> A fresh start then gives a correct full load.
//  6. len=20000, MAX_BITBYTES=16:
//     -> exactly 4 strobes; last rom_addr=15; data matches {b[i..i+3]} for all words.

Source files
------------

// File: rtl/bitstream_self_loader_if.sv
// Bundles the loader's control, ROM read and fabric self-write signals.
// The master side is the loader; the slave side is its surroundings (controller, ROM, fabric).
interface bitstream_self_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [ADDR_W:0]   len_bytes;
    logic              abort;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [31:0]       SelfWriteData;
    logic              SelfWriteStrobe;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] words_written;

    modport master (
        input  start, len_bytes, abort, rom_data,
        output rom_en, rom_addr, SelfWriteData, SelfWriteStrobe, busy, done, words_written
    );

    modport slave (
        output start, len_bytes, abort, rom_data,
        input  rom_en, rom_addr, SelfWriteData, SelfWriteStrobe, busy, done, words_written
    );
endinterface

// File: rtl/bitstream_self_loader.sv
// Streams a byte-wide bitstream from synchronous ROM into the eFPGA self-write port,
// packing 4 bytes big-endian per word and spacing each strobe with setup/hold gaps.
module bitstream_self_loader #(
    parameter int MAX_BITBYTES = 16384,
    parameter int ADDR_W       = 14,
    parameter int PRE_GAP      = 2,
    parameter int POST_GAP     = 2
) (
    input  logic CLK,
    input  logic resetn,
    bitstream_self_loader_if.master bus
);
    localparam int              FETCH_LEN  = 5;
    localparam logic [ADDR_W:0] MAX_LEN    = (ADDR_W+1)'(MAX_BITBYTES);
    localparam logic [7:0]      FETCH_LAST = 8'(FETCH_LEN - 1);
    localparam logic [7:0]      SETUP_LAST = 8'(PRE_GAP - 1);
    localparam logic [7:0]      HOLD_LAST  = 8'(POST_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   pad_idx;
    logic [ADDR_W-1:0] base;
    logic [23:0]       lanes;
    logic [31:0]       data_q;
    logic [ADDR_W-2:0] words_q;
    logic [7:0]        fetch_byte;
    logic              accept;
    logic              phase_last;
    logic              word_last;

    assign len_clamped = (bus.len_bytes > MAX_LEN) ? MAX_LEN : bus.len_bytes;
    assign accept      = (state == S_IDLE) && bus.start && !bus.abort;
    assign word_last   = ({1'b0, base} + (ADDR_W+1)'(4)) >= len_q;

    // The byte arriving on FETCH cycle cnt was addressed one cycle earlier.
    assign pad_idx    = {1'b0, base} + (ADDR_W+1)'(cnt) - (ADDR_W+1)'(1);
    assign fetch_byte = (pad_idx >= len_q) ? 8'h00 : bus.rom_data;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        phase_last = 1'b1;
        case (state)
            S_FETCH: phase_last = (cnt == FETCH_LAST);
            S_SETUP: phase_last = (cnt == SETUP_LAST);
            S_HOLD:  phase_last = (cnt == HOLD_LAST);
            default: phase_last = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state_nxt = (len_clamped == '0) ? S_DONE : S_FETCH;
                S_FETCH:  if (phase_last) state_nxt = S_SETUP;
                S_SETUP:  if (phase_last) state_nxt = S_STROBE;
                S_STROBE: state_nxt = S_HOLD;
                S_HOLD:   if (phase_last) state_nxt = word_last ? S_DONE : S_FETCH;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            len_q   <= '0;
            base    <= '0;
            lanes   <= '0;
            data_q  <= '0;
            words_q <= '0;
        end else begin
            if (state_nxt != state || state == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (accept) begin
                len_q   <= len_clamped;
                base    <= '0;
                words_q <= '0;
            end

            if (state == S_HOLD && state_nxt == S_FETCH) begin
                base <= base + ADDR_W'(4);
            end

            // The last byte bypasses the lane register so the word lands on the FETCH->SETUP edge.
            if (state == S_FETCH && cnt != 8'd0) begin
                if (state_nxt == S_SETUP) begin
                    data_q <= {lanes, fetch_byte};
                end else begin
                    lanes <= {lanes[15:0], fetch_byte};
                end
            end

            if (state == S_SETUP && state_nxt == S_STROBE) begin
                words_q <= words_q + (ADDR_W-1)'(1);
            end
        end
    end

    always_comb begin
        bus.rom_en          = 1'b0;
        bus.rom_addr        = '0;
        bus.SelfWriteStrobe = 1'b0;
        bus.busy            = 1'b0;
        bus.done            = 1'b0;
        case (state)
            S_FETCH: begin
                bus.busy = 1'b1;
                if (cnt < 8'd4) begin
                    bus.rom_en   = 1'b1;
                    bus.rom_addr = {base[ADDR_W-1:2], cnt[1:0]};
                end
            end
            S_SETUP, S_HOLD: bus.busy = 1'b1;
            S_STROBE: begin
                bus.busy            = 1'b1;
                bus.SelfWriteStrobe = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    assign bus.SelfWriteData = data_q;
    assign bus.words_written = words_q;
endmodule

// File: tb/tb_bitstream_self_loader.sv
// Randomized self-checking bench: a time-indexed load model predicts every output each cycle,
// plus literal expectations for the directed scenarios.
module tb_bitstream_self_loader;
    localparam int MAX    = 64;
    localparam int ADDR_W = 6;
    localparam int PRE    = 2;
    localparam int POST   = 2;
    localparam int FETCH  = 5;
    localparam int PERIOD = FETCH + PRE + 1 + POST;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    bitstream_self_loader_if #(.ADDR_W(ADDR_W)) bus ();

    bitstream_self_loader #(
        .MAX_BITBYTES(MAX),
        .ADDR_W      (ADDR_W),
        .PRE_GAP     (PRE),
        .POST_GAP    (POST)
    ) dut (
        .CLK   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [MAX];
    logic [7:0] rom_q = 8'h00;
    always @(posedge clk) if (bus.rom_en) rom_q <= rom[bus.rom_addr];
    assign bus.rom_data = rom_q;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Model: a load is a timeline indexed by cycles since acceptance.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    int          m_nw     = 0;
    int          m_len    = 0;
    logic [31:0] m_data   = '0;
    int          m_ww     = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } strobe_t;
    strobe_t strobes[$];
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, en_cnt = 0, max_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got 0x%h, want 0x%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = 4 * k + i;
            w = {w[23:0], (idx < m_len) ? rom[idx] : 8'h00};
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_active = 1'b0;
            m_t      = 0;
            m_data   = '0;
            m_ww     = 0;
        end else if (!m_active) begin
            if (bus.start && !bus.abort) begin
                m_len    = (int'(bus.len_bytes) > MAX) ? MAX : int'(bus.len_bytes);
                m_nw     = (m_len + 3) / 4;
                m_t      = 0;
                m_ww     = 0;
                m_active = 1'b1;
            end
        end else if (bus.abort || m_t == m_nw * PERIOD) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (m_t < m_nw * PERIOD) begin
                if (m_t % PERIOD == FETCH)       m_data = model_word(m_t / PERIOD);
                if (m_t % PERIOD == FETCH + PRE) m_ww   = m_t / PERIOD + 1;
            end
        end
    end

    initial forever begin
        bit e_busy, e_done, e_strobe, e_en;
        int e_addr;
        @(posedge clk);
        #2;
        cyc++;
        e_busy = 0; e_done = 0; e_strobe = 0; e_en = 0; e_addr = 0;
        if (m_active) begin
            if (m_t == m_nw * PERIOD) begin
                e_done = 1;
            end else begin
                e_busy   = 1;
                e_en     = (m_t % PERIOD) < 4;
                e_addr   = 4 * (m_t / PERIOD) + m_t % PERIOD;
                e_strobe = (m_t % PERIOD) == FETCH + PRE;
            end
        end
        check("busy",   32'(bus.busy),            32'(e_busy));
        check("done",   32'(bus.done),            32'(e_done));
        check("strobe", 32'(bus.SelfWriteStrobe), 32'(e_strobe));
        check("rom_en", 32'(bus.rom_en),          32'(e_en));
        if (e_en) check("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
        check("data",   bus.SelfWriteData,        m_data);
        check("words",  32'(bus.words_written),   32'(m_ww));

        if (bus.SelfWriteStrobe) strobes.push_back('{cyc, bus.SelfWriteData});
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy) busy_cnt++;
        if (bus.rom_en) begin
            en_cnt++;
            if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
        end
    end

    task automatic clear_logs();
        strobes.delete();
        done_cnt = 0; busy_cnt = 0; en_cnt = 0; max_addr = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   32'(bus.busy),            32'h0);
        check({tag, "_done"},   32'(bus.done),            32'h0);
        check({tag, "_strobe"}, 32'(bus.SelfWriteStrobe), 32'h0);
        check({tag, "_rom_en"}, 32'(bus.rom_en),          32'h0);
        check({tag, "_addr"},   32'(bus.rom_addr),        32'h0);
        check({tag, "_data"},   bus.SelfWriteData,        32'h0);
        check({tag, "_words"},  32'(bus.words_written),   32'h0);
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len_bytes = (ADDR_W+1)'(len);
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit noisy);
        int n;
        n = 0;
        while ((m_active || bus.busy || bus.done) && n < budget) begin
            @(negedge clk);
            if (noisy) begin
                bus.abort     = ($urandom_range(0, 199) == 0);
                bus.start     = ($urandom_range(0, 15) == 0);
                bus.len_bytes = (ADDR_W+1)'($urandom_range(0, 127));
            end
            n++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("load_finished", 32'(n < budget), 32'h1);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len_bytes = '0;
        for (int i = 0; i < MAX; i++) rom[i] = 8'(i + 1);
        repeat (3) @(negedge clk);
        check_zero("reset");
        resetn = 1'b1;

        // Eight bytes: two full words, strobes one period apart.
        clear_logs();
        pulse_start(8);
        wait_idle(300, 1'b0);
        check("t1_strobes", 32'(strobes.size()), 32'd2);
        if (strobes.size() == 2) begin
            check("t1_word0",   strobes[0].data, 32'h01020304);
            check("t1_word1",   strobes[1].data, 32'h05060708);
            check("t1_spacing", 32'(strobes[1].cyc - strobes[0].cyc), 32'd10);
            check("t1_done_lag", 32'(done_cyc - strobes[1].cyc), 32'd3);
        end
        check("t1_words", 32'(bus.words_written), 32'd2);

        // Six bytes: tail of the second word is zero padded.
        clear_logs();
        pulse_start(6);
        wait_idle(300, 1'b0);
        check("t2_strobes", 32'(strobes.size()), 32'd2);
        if (strobes.size() == 2) check("t2_word1", strobes[1].data, 32'h05060000);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_words", 32'(bus.words_written), 32'd2);

        // Zero length: only a done pulse.
        clear_logs();
        pulse_start(0);
        wait_idle(50, 1'b0);
        check("t3_strobes", 32'(strobes.size()), 32'd0);
        check("t3_rom_en",  32'(en_cnt),         32'd0);
        check("t3_busy",    32'(busy_cnt),       32'd0);
        check("t3_done",    32'(done_cnt),       32'd1);

        // Abort one cycle after the second strobe.
        clear_logs();
        pulse_start(16);
        n = 0;
        while (strobes.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_strobe2", 32'(n < 200), 32'h1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_strobes", 32'(strobes.size()),      32'd2);
        check("t4_done",    32'(done_cnt),            32'd0);
        check("t4_busy",    32'(bus.busy),            32'd0);
        check("t4_words",   32'(bus.words_written),   32'd2);

        // Start and abort together in idle: start dropped.
        clear_logs();
        @(negedge clk);
        bus.start = 1'b1; bus.len_bytes = 7'd8; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (5) @(negedge clk);
        check("t7_busy",   32'(busy_cnt), 32'd0);
        check("t7_rom_en", 32'(en_cnt),   32'd0);

        // Second start mid-load is ignored; reset in SETUP clears everything at once.
        clear_logs();
        pulse_start(16);
        repeat (3) @(negedge clk);
        pulse_start(4);
        n = 0;
        while (!(m_active && m_t % PERIOD == FETCH && m_t >= PERIOD) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_setup", 32'(n < 200), 32'h1);
        resetn = 1'b0;
        #1;
        check_zero("t5_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        pulse_start(16);
        wait_idle(300, 1'b0);
        check("t5_strobes", 32'(strobes.size()),    32'd4);
        check("t5_words",   32'(bus.words_written), 32'd4);

        // Oversized request is clamped to the store size; last address is the final byte.
        for (int i = 0; i < MAX; i++) rom[i] = 8'($urandom);
        clear_logs();
        pulse_start(100);
        wait_idle(400, 1'b0);
        check("t6_strobes",  32'(strobes.size()), 32'd16);
        check("t6_max_addr", 32'(max_addr),       32'd63);

        // Random lengths, contents, stray starts and aborts.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < MAX; i++) rom[i] = 8'($urandom);
            pulse_start(int'($urandom_range(0, 127)));
            wait_idle(400, 1'b1);
            repeat (2) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d: got running, want finished", cyc);
        $fatal(1, "simulation did not terminate");
    end
endmodule
